// File: rtl/commit_trace_serializer.sv
// Commit-trace FIFO: up to CHANNELS retires per cycle in, one entry per handshake out to difftest.
// Optional per-entry 64-bit push sequence tag on debug_seq when COMMIT_TRACE_SEQ_EN is defined.
module commit_trace_serializer #(
   parameter int CHANNELS = 2,
   parameter int DEPTH    = 8,
   parameter int XLEN     = 64
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [CHANNELS-1:0]      in_commit,
   input  logic [CHANNELS*XLEN-1:0] in_pc,
   input  logic [CHANNELS*5-1:0]    in_wnum,
   input  logic [CHANNELS*XLEN-1:0] in_wdata,
   output logic                     in_ready,
   output logic                     debug_commit,
   output logic [XLEN-1:0]          debug_pc,
   output logic [4:0]               debug_rf_wnum,
   output logic [XLEN-1:0]          debug_rf_wdata,
`ifdef COMMIT_TRACE_SEQ_EN
   output logic [63:0]              debug_seq,
`endif
   input  logic                     out_ready,
   output logic                     overflow
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] LP_RDY_MAX = DEPTH[PW:0] - CHANNELS[PW:0];

   logic [XLEN-1:0] r_mem_pc    [DEPTH];
   logic [4:0]      r_mem_wnum  [DEPTH];
   logic [XLEN-1:0] r_mem_wdata [DEPTH];
   logic [PW-1:0]   r_rd_ptr;
   logic [PW-1:0]   r_wr_ptr;
   logic [PW:0]     r_count;
   logic            r_overflow;

   logic [PW:0]     w_acc;
   logic [PW:0]     w_pcnt;
   logic [PW-1:0]   w_off  [CHANNELS];
   logic [PW-1:0]   w_slot [CHANNELS];
   logic            w_push;
   logic            w_pop;
   logic            w_drop;
   logic [PW:0]     w_cnt_nxt;

`ifdef COMMIT_TRACE_SEQ_EN
   logic [63:0]     r_mem_seq [DEPTH];
   logic [63:0]     r_seq;
   logic [63:0]     w_seq_tag [CHANNELS];
`endif

   // Compaction: each valid channel lands at wr_ptr + (number of valid lower channels)
   always_comb begin
      w_acc = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         w_off[i]  = w_acc[PW-1:0];
         w_slot[i] = r_wr_ptr + w_acc[PW-1:0];
         w_acc     = w_acc + {{PW{1'b0}}, in_commit[i]};
      end
      w_pcnt = w_acc;
   end

`ifdef COMMIT_TRACE_SEQ_EN
   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         w_seq_tag[i] = r_seq + {{(64-PW){1'b0}}, w_off[i]};
      end
   end
`endif

   // in_ready looks only at the registered count, so a same-cycle pop never widens it
   assign in_ready  = (r_count <= LP_RDY_MAX);
   assign w_push    = (in_commit != '0) && in_ready;
   assign w_drop    = (in_commit != '0) && !in_ready;
   assign w_pop     = debug_commit && out_ready;
   assign w_cnt_nxt = r_count + (w_push ? w_pcnt : '0) - {{PW{1'b0}}, w_pop};

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_rd_ptr   <= '0;
         r_wr_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
         for (int k = 0; k < DEPTH; k++) begin
            r_mem_pc[k]    <= '0;
            r_mem_wnum[k]  <= '0;
            r_mem_wdata[k] <= '0;
         end
`ifdef COMMIT_TRACE_SEQ_EN
         r_seq <= '0;
         for (int k = 0; k < DEPTH; k++) begin
            r_mem_seq[k] <= '0;
         end
`endif
      end else begin
         if (w_push) begin
            for (int i = 0; i < CHANNELS; i++) begin
               if (in_commit[i]) begin
                  r_mem_pc[w_slot[i]]    <= in_pc[i*XLEN +: XLEN];
                  r_mem_wnum[w_slot[i]]  <= in_wnum[i*5 +: 5];
                  r_mem_wdata[w_slot[i]] <= in_wdata[i*XLEN +: XLEN];
`ifdef COMMIT_TRACE_SEQ_EN
                  r_mem_seq[w_slot[i]]   <= w_seq_tag[i];
`endif
               end
            end
            r_wr_ptr <= r_wr_ptr + w_pcnt[PW-1:0];
`ifdef COMMIT_TRACE_SEQ_EN
            r_seq    <= r_seq + {{(63-PW){1'b0}}, w_pcnt};
`endif
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + {{(PW-1){1'b0}}, 1'b1};
         end
         r_count <= w_cnt_nxt;
         if (w_drop) begin
            r_overflow <= 1'b1;
         end
      end
   end

   assign debug_commit   = (r_count != '0);
   assign debug_pc       = r_mem_pc[r_rd_ptr];
   assign debug_rf_wnum  = r_mem_wnum[r_rd_ptr];
   assign debug_rf_wdata = r_mem_wdata[r_rd_ptr];
   assign overflow       = r_overflow;
`ifdef COMMIT_TRACE_SEQ_EN
   assign debug_seq      = r_mem_seq[r_rd_ptr];
`endif

endmodule

// File: tb/tb_commit_trace_serializer.sv
// Directed bench for commit_trace_serializer (CHANNELS=2, DEPTH=8, XLEN=64).
// Checks debug_seq too when COMMIT_TRACE_SEQ_EN is defined.
module tb_commit_trace_serializer;

   logic         clock = 1'b0;
   logic         reset;
   logic [1:0]   in_commit;
   logic [127:0] in_pc;
   logic [9:0]   in_wnum;
   logic [127:0] in_wdata;
   logic         in_ready;
   logic         debug_commit;
   logic [63:0]  debug_pc;
   logic [4:0]   debug_rf_wnum;
   logic [63:0]  debug_rf_wdata;
   logic         out_ready;
   logic         overflow;
`ifdef COMMIT_TRACE_SEQ_EN
   logic [63:0]  debug_seq;
`endif

   int n_chk = 0;
   int n_err = 0;

   commit_trace_serializer #(.CHANNELS(2), .DEPTH(8), .XLEN(64)) dut (
      .clock(clock), .reset(reset), .in_commit(in_commit), .in_pc(in_pc),
      .in_wnum(in_wnum), .in_wdata(in_wdata), .in_ready(in_ready),
      .debug_commit(debug_commit), .debug_pc(debug_pc), .debug_rf_wnum(debug_rf_wnum),
      .debug_rf_wdata(debug_rf_wdata),
`ifdef COMMIT_TRACE_SEQ_EN
      .debug_seq(debug_seq),
`endif
      .out_ready(out_ready), .overflow(overflow));

   always #5 clock = ~clock;

   typedef struct {
      logic [1:0]  commit;
      logic [63:0] pc0, pc1;
      logic [4:0]  wn0, wn1;
      logic [63:0] wd0, wd1;
      logic        ordy;
      logic        e_commit;
      logic        chk_data;
      logic [63:0] e_pc;
      logic [4:0]  e_wn;
      logic [63:0] e_wd;
      logic        e_ready;
   } vec_t;

   vec_t vt[12];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic [1:0] c, input logic [63:0] p0, input logic [63:0] p1,
                        input logic [4:0] n0, input logic [4:0] n1,
                        input logic [63:0] d0, input logic [63:0] d1, input logic ordy);
      in_commit = c;
      in_pc     = {p1, p0};
      in_wnum   = {n1, n0};
      in_wdata  = {d1, d0};
      out_ready = ordy;
   endtask

   task automatic idle(input logic ordy);
      drive(2'b00, 64'h0, 64'h0, 5'd0, 5'd0, 64'h0, 64'h0, ordy);
   endtask

   task automatic do_reset();
      idle(1'b0);
      reset = 1'b0;
      step();
      step();
      reset = 1'b1;
   endtask

   initial begin
      vt[0]  = '{2'b11, 64'h80000000, 64'h80000004, 5'd1, 5'd2, 64'h11, 64'h22, 1'b1, 1'b1, 1'b1, 64'h80000000, 5'd1, 64'h11, 1'b1};
      vt[1]  = '{2'b00, 64'h0, 64'h0, 5'd0, 5'd0, 64'h0, 64'h0, 1'b1, 1'b1, 1'b1, 64'h80000004, 5'd2, 64'h22, 1'b1};
      vt[2]  = '{2'b00, 64'h0, 64'h0, 5'd0, 5'd0, 64'h0, 64'h0, 1'b1, 1'b0, 1'b0, 64'h0, 5'd0, 64'h0, 1'b1};
      vt[3]  = '{2'b10, 64'h9999, 64'h1000, 5'd3, 5'd5, 64'h99, 64'hAB, 1'b0, 1'b1, 1'b1, 64'h1000, 5'd5, 64'hAB, 1'b1};
      vt[4]  = '{2'b00, 64'h0, 64'h0, 5'd0, 5'd0, 64'h0, 64'h0, 1'b0, 1'b1, 1'b1, 64'h1000, 5'd5, 64'hAB, 1'b1};
      vt[5]  = '{2'b00, 64'h0, 64'h0, 5'd0, 5'd0, 64'h0, 64'h0, 1'b1, 1'b0, 1'b0, 64'h0, 5'd0, 64'h0, 1'b1};
      vt[6]  = '{2'b01, 64'h2000, 64'h7777, 5'd7, 5'd0, 64'h77, 64'h0, 1'b1, 1'b1, 1'b1, 64'h2000, 5'd7, 64'h77, 1'b1};
      vt[7]  = '{2'b01, 64'h2004, 64'h7777, 5'd8, 5'd0, 64'h78, 64'h0, 1'b1, 1'b1, 1'b1, 64'h2004, 5'd8, 64'h78, 1'b1};
      vt[8]  = '{2'b11, 64'h3000, 64'h3004, 5'd9, 5'd10, 64'h90, 64'hA0, 1'b0, 1'b1, 1'b1, 64'h2004, 5'd8, 64'h78, 1'b1};
      vt[9]  = '{2'b00, 64'h0, 64'h0, 5'd0, 5'd0, 64'h0, 64'h0, 1'b1, 1'b1, 1'b1, 64'h3000, 5'd9, 64'h90, 1'b1};
      vt[10] = '{2'b00, 64'h0, 64'h0, 5'd0, 5'd0, 64'h0, 64'h0, 1'b1, 1'b1, 1'b1, 64'h3004, 5'd10, 64'hA0, 1'b1};
      vt[11] = '{2'b00, 64'h0, 64'h0, 5'd0, 5'd0, 64'h0, 64'h0, 1'b1, 1'b0, 1'b0, 64'h0, 5'd0, 64'h0, 1'b1};

      // Reset release
      reset = 1'b1;
      do_reset();
      chk("rst_commit", {63'd0, debug_commit}, 64'd0);
      chk("rst_pc", debug_pc, 64'd0);
      chk("rst_wnum", {59'd0, debug_rf_wnum}, 64'd0);
      chk("rst_wdata", debug_rf_wdata, 64'd0);
      chk("rst_ready", {63'd0, in_ready}, 64'd1);
      chk("rst_ovf", {63'd0, overflow}, 64'd0);
`ifdef COMMIT_TRACE_SEQ_EN
      chk("rst_seq", debug_seq, 64'd0);
`endif
      step();
      chk("rst_idle_commit", {63'd0, debug_commit}, 64'd0);

      // Table-driven ordering / compaction / concurrent push-pop
      for (int v = 0; v < 12; v++) begin
         drive(vt[v].commit, vt[v].pc0, vt[v].pc1, vt[v].wn0, vt[v].wn1, vt[v].wd0, vt[v].wd1, vt[v].ordy);
         step();
         chk($sformatf("v%0d_commit", v), {63'd0, debug_commit}, {63'd0, vt[v].e_commit});
         chk($sformatf("v%0d_ready", v), {63'd0, in_ready}, {63'd0, vt[v].e_ready});
         chk($sformatf("v%0d_ovf", v), {63'd0, overflow}, 64'd0);
         if (vt[v].chk_data) begin
            chk($sformatf("v%0d_pc", v), debug_pc, vt[v].e_pc);
            chk($sformatf("v%0d_wnum", v), {59'd0, debug_rf_wnum}, {59'd0, vt[v].e_wn});
            chk($sformatf("v%0d_wdata", v), debug_rf_wdata, vt[v].e_wd);
         end
      end

      // Fill to full, then drain in push order
      do_reset();
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("fill%0d_ready", k), {63'd0, in_ready}, 64'd1);
         drive(2'b11, 64'hA000 + 64'(16*k), 64'hA000 + 64'(16*k + 8), 5'd1, 5'd2, 64'h0, 64'h0, 1'b0);
         step();
      end
      idle(1'b0);
      chk("full_ready", {63'd0, in_ready}, 64'd0);
      chk("full_commit", {63'd0, debug_commit}, 64'd1);
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("full_pc%0d", k), debug_pc, 64'hA000 + 64'(8*k));
         idle(1'b1);
         step();
         if (k == 0) chk("full_pop1_ready", {63'd0, in_ready}, 64'd0);
         if (k == 1) chk("full_pop2_ready", {63'd0, in_ready}, 64'd1);
      end
      chk("full_drained", {63'd0, debug_commit}, 64'd0);
      chk("full_ovf", {63'd0, overflow}, 64'd0);

      // Overflow with 7 entries queued
      do_reset();
      for (int k = 0; k < 3; k++) begin
         drive(2'b11, 64'hB000 + 64'(16*k), 64'hB000 + 64'(16*k + 8), 5'd0, 5'd0, 64'h0, 64'h0, 1'b0);
         step();
      end
      drive(2'b01, 64'hB030, 64'h0, 5'd0, 5'd0, 64'h0, 64'h0, 1'b0);
      step();
      chk("ovf7_ready", {63'd0, in_ready}, 64'd0);
      drive(2'b01, 64'hDEAD, 64'h0, 5'd0, 5'd0, 64'h0, 64'h0, 1'b0);
      step();
      chk("ovf_set", {63'd0, overflow}, 64'd1);
      idle(1'b0);
      step();
      chk("ovf_sticky", {63'd0, overflow}, 64'd1);
      for (int k = 0; k < 7; k++) begin
         chk($sformatf("ovf_commit%0d", k), {63'd0, debug_commit}, 64'd1);
         chk($sformatf("ovf_pc%0d", k), debug_pc, 64'hB000 + 64'(8*k));
         idle(1'b1);
         step();
      end
      chk("ovf_drained", {63'd0, debug_commit}, 64'd0);
      chk("ovf_still_set", {63'd0, overflow}, 64'd1);
      drive(2'b11, 64'hC000, 64'hC008, 5'd0, 5'd0, 64'h0, 64'h0, 1'b0);
      step();
      chk("flush_pre_commit", {63'd0, debug_commit}, 64'd1);
      idle(1'b0);
      reset = 1'b0;
      step();
      reset = 1'b1;
      chk("flush_commit", {63'd0, debug_commit}, 64'd0);
      chk("flush_ovf", {63'd0, overflow}, 64'd0);
      chk("flush_pc", debug_pc, 64'd0);
      chk("flush_ready", {63'd0, in_ready}, 64'd1);

      // Wrap with continuous single-channel pushes and pops
      do_reset();
      for (int k = 0; k < 20; k++) begin
         drive(2'b01, 64'h5000 + 64'(4*k), 64'h0, 5'(k), 5'd0, 64'(k), 64'h0, 1'b1);
         step();
         chk($sformatf("wrap%0d_commit", k), {63'd0, debug_commit}, 64'd1);
         chk($sformatf("wrap%0d_pc", k), debug_pc, 64'h5000 + 64'(4*k));
         chk($sformatf("wrap%0d_ready", k), {63'd0, in_ready}, 64'd1);
`ifdef COMMIT_TRACE_SEQ_EN
         chk($sformatf("wrap%0d_seq", k), debug_seq, 64'(k));
`endif
      end
      idle(1'b1);
      step();
      chk("wrap_empty", {63'd0, debug_commit}, 64'd0);
      chk("wrap_ovf", {63'd0, overflow}, 64'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
